regfile_wb_scheduler: RTL and testbench
=======================================

# regfile_wb_scheduler

Write-port scheduler and register scoreboard for the pipelined CPU's 32×32 register file. Shares the single register-file write port between the in-order WB stage and the multi-cycle multiply/divide unit (MDU), buffering MDU results in a small FIFO. Tracks registers with MDU writes still outstanding and raises a decode-stage stall on RAW/WAW hazards against them. Sits between ID, WB, the MDU and the register file's write port.

## Interface
- DEPTH, 2: MDU result FIFO entries, power of two, ≥2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  decode stage holds a valid instruction
- id_rs, id_rt  in  5  source registers read by the decode instruction
- id_rs_used, id_rt_used  in  1  source actually read
- id_rd  in  5  destination register
- id_rd_we  in  1  instruction writes id_rd
- id_mdu  in  1  instruction is an MDU op; its id_rd result returns via mdu_*
- stall  out  1  hold IF/ID, bubble into EX (combinational)
- wb_we, wb_rd, wb_data  in  1/5/32  pipeline write-back request
- mdu_valid, mdu_rd, mdu_data  in  1/5/32  MDU result offer
- mdu_ready  out  1  FIFO can accept a result
- rf_we, rf_waddr, rf_wdata  out  1/5/32  register-file write port (combinational)
- busy_vec  out  32  scoreboard state, bit 0 always 0
- pending  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- MDU accept: mdu_valid && mdu_ready pushes {rd, data}. mdu_ready = !full; no pop-through when full.
- Port arbitration, each cycle:
  - WB wins when wb_we && wb_rd != 0: rf_* = wb_*.
  - Otherwise, if the FIFO is non-empty, pop the head: rf_we = 1, rf_* = head.
  - Otherwise rf_we = 0.
- WB to r0 is discarded and frees the port for the FIFO.
- Scoreboard:
  - busy[r] sets at the edge where id_valid && id_mdu && id_rd_we && !stall && id_rd == r, r != 0.
  - busy[r] clears at the edge where the FIFO pop writes r.
  - If set and clear of the same r coincide, set wins.
- stall = id_valid && (hazard on id_rs via id_rs_used, hazard on id_rt via id_rt_used, or hazard on id_rd via id_rd_we), each tested against busy_eff. Register 0 never stalls.
- busy_eff is defined under Configuration.
- An MDU result whose rd is not busy is still written. No error is flagged.

## Timing
- Reset: FIFO emptied, busy_vec = 0, pending = 0, mdu_ready = 1, rf_we = 0 (absent wb_we), stall = 0.
- Reset mid-operation discards buffered results and busy bits.
- MDU result accepted at edge N is written to the register file at edge N+1 at the earliest. Each cycle of WB priority adds one cycle.
- Full FIFO with simultaneous pop and offer: the offer is refused this cycle and accepted next cycle.
- WB occupying the port continuously starves the FIFO. ID stalls prevent indefinite starvation, because stalled ID bubbles reach WB within the pipeline depth.
- pending and busy_vec are registered.

## Configuration
- REGFILE_SB_EARLY_CLEAR_EN defined:
  - busy_eff = busy_vec & ~(the register popped this cycle).
  - The stall drops in the same cycle as the write, relying on the register file's write-through read.
  - Re-issuing an MDU op to that register in that cycle is allowed; set wins.
- REGFILE_SB_EARLY_CLEAR_EN undefined: busy_eff = busy_vec. The stall drops the cycle after the write.

## Structure
- Shared package holds:
  - register-index width (5) and data width (32);
  - REG_ZERO constant;
  - FIFO entry struct {rd, data}.
- Sub-module: regfile_wb_fifo. Synchronous DEPTH-entry FIFO with push, pop, full, empty and count, asynchronous reset. The arbitration and scoreboard stay in the top module.

## Test plan
1. Issue an MDU op to r5, so busy_vec = 0x20. Decode reads r5 → stall = 1. MDU returns r5 = 0x1234 with wb_we = 0 → rf_we, waddr = 5, wdata = 0x1234 the next cycle. busy clears; stall drops in that cycle (macro on) or one cycle later (macro off).
2. wb_we = 1, wb_rd = 3 held for 3 cycles while MDU r7 = 0xBEEF is pending → r3 is written for 3 cycles, then r7. pending goes 1 → 0 on the 4th edge.
3. Fill the FIFO with 2 MDU results while WB is busy → mdu_ready = 0, and a third offer is held until the port frees. Results are written in arrival order.
4. wb_we = 1, wb_rd = 0 with the FIFO non-empty → the FIFO head is written that cycle.
5. Decode MDU op to r9 while r9 is busy → stall (WAW). A stalled op to r9 does not set busy twice.
6. Assert reset with 2 entries pending and busy_vec = 0x300 → pending = 0, busy_vec = 0, mdu_ready = 1 immediately, with no writes after reset.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types for the register-file write-port scheduler.
// Register index and data widths, r0 constant, MDU FIFO entry.
package regfile_wb_scheduler_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } mdu_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// DEPTH-entry synchronous FIFO buffering MDU results.
// Pointers wrap naturally because DEPTH is a power of two.
module regfile_wb_fifo
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  mdu_entry_t             wdata,
  output mdu_entry_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  mdu_entry_t    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count
             + {{AW{1'b0}}, do_push}
             - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port arbiter (WB over MDU FIFO) and MDU scoreboard.
// Optional REGFILE_SB_EARLY_CLEAR_EN: stall drops in the pop cycle.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic [4:0]             id_rd,
  input  logic                   id_rd_we,
  input  logic                   id_mdu,
  output logic                   stall,
  input  logic                   wb_we,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_data,
  input  logic                   mdu_valid,
  input  logic [4:0]             mdu_rd,
  input  logic [31:0]            mdu_data,
  output logic                   mdu_ready,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [31:0]            rf_wdata,
  output logic [31:0]            busy_vec,
  output logic [$clog2(DEPTH):0] pending
);

  mdu_entry_t  head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        wb_win;
  logic [31:0] pop_mask;
  logic [31:0] set_mask;
  logic [31:0] busy_eff;
  logic        hz_rs;
  logic        hz_rt;
  logic        hz_rd;

  assign mdu_ready = !full;
  assign push      = mdu_valid && !full;
  assign wb_win    = wb_we && (wb_rd != REG_ZERO);
  assign pop       = !empty && !wb_win;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ('{rd: mdu_rd, data: mdu_data}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    unique case (1'b1)
      wb_win: begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end
      pop: begin
        rf_we    = 1'b1;
        rf_waddr = head.rd;
        rf_wdata = head.data;
      end
      default: ;
    endcase
  end

  assign pop_mask = pop ? (32'd1 << head.rd) : '0;

`ifdef REGFILE_SB_EARLY_CLEAR_EN
  assign busy_eff = busy_vec & ~pop_mask;
`else
  assign busy_eff = busy_vec;
`endif

  assign hz_rs = id_rs_used && (id_rs != REG_ZERO) && busy_eff[id_rs];
  assign hz_rt = id_rt_used && (id_rt != REG_ZERO) && busy_eff[id_rt];
  assign hz_rd = id_rd_we && (id_rd != REG_ZERO) && busy_eff[id_rd];
  assign stall = id_valid && (hz_rs || hz_rt || hz_rd);

  assign set_mask = (id_valid && id_mdu && id_rd_we && !stall
                     && id_rd != REG_ZERO)
                  ? (32'd1 << id_rd) : '0;

  // Set is applied after clear so a same-cycle re-issue keeps the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= ((busy_vec & ~pop_mask) | set_mask) & ~32'd1;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed + random bench for regfile_wb_scheduler.
// Reference: result queue plus per-register busy flags.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  localparam int DEPTH = 2;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_rs_used, id_rt_used, id_rd_we, id_mdu;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          stall;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          mdu_valid;
  logic [4:0]    mdu_rd;
  logic [31:0]   mdu_data;
  logic          mdu_ready;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [31:0]   busy_vec;
  logic [PW-1:0] pending;

  int checks = 0;
  int errors = 0;

  mdu_entry_t  q[$];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_mdu(id_mdu),
    .stall(stall),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec), .pending(pending)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs_used = 0; id_rt_used = 0;
    id_rd_we = 0; id_mdu = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    logic        wbwin, pop, st, acc;
    logic [31:0] eff;
    mdu_entry_t  h;
    #1;
    wbwin = wb_we && wb_rd != 0;
    pop   = !wbwin && q.size() > 0;
    eff   = m_busy;
`ifdef REGFILE_SB_EARLY_CLEAR_EN
    if (pop) eff[q[0].rd] = 1'b0;
`endif
    st = id_valid && ((id_rs_used && id_rs != 0 && eff[id_rs])
                   || (id_rt_used && id_rt != 0 && eff[id_rt])
                   || (id_rd_we && id_rd != 0 && eff[id_rd]));
    acc = mdu_valid && q.size() < DEPTH;
    chk("stall", stall, st);
    chk("mdu_ready", mdu_ready, q.size() < DEPTH);
    chk("rf_we", rf_we, wbwin || pop);
    if (wbwin) begin
      chk("rf_waddr_wb", rf_waddr, wb_rd);
      chk("rf_wdata_wb", rf_wdata, wb_data);
    end else if (pop) begin
      chk("rf_waddr_fifo", rf_waddr, q[0].rd);
      chk("rf_wdata_fifo", rf_wdata, q[0].data);
    end
    chk("pending", pending, q.size());
    chk("busy_vec", busy_vec, m_busy);
    @(posedge clk);
    if (pop) begin
      h = q.pop_front();
      m_busy[h.rd] = 1'b0;
    end
    if (acc) q.push_back('{rd: mdu_rd, data: mdu_data});
    if (id_valid && id_mdu && id_rd_we && !st && id_rd != 0)
      m_busy[id_rd] = 1'b1;
    @(negedge clk);
  endtask

  task automatic mdu_issue(logic [4:0] rd);
    id_valid = 1; id_mdu = 1; id_rd_we = 1; id_rd = rd;
  endtask

  task automatic id_clear();
    id_valid = 0; id_mdu = 0; id_rd_we = 0;
    id_rs_used = 0; id_rt_used = 0;
  endtask

  initial begin
    idle_inputs();
    m_busy = '0;
    reset  = 1'b1;
    #1;
    chk("reset_pending", pending, 0);
    chk("reset_busy", busy_vec, 0);
    chk("reset_ready", mdu_ready, 1);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_stall", stall, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: MDU op to r5, dependent read stalls until the result lands
    mdu_issue(5);
    cycle();
    id_clear();
    chk("t1_busy", busy_vec, 32'h20);
    id_valid = 1; id_rs = 5; id_rs_used = 1;
    mdu_valid = 1; mdu_rd = 5; mdu_data = 32'h1234;
    #1 chk("t1_stall", stall, 1);
    cycle();
    mdu_valid = 0;
    #1 chk("t1_rf_waddr", rf_waddr, 5);
    chk("t1_rf_wdata", rf_wdata, 32'h1234);
    cycle();
    cycle();
    id_clear();
    chk("t1_busy_clear", busy_vec, 0);

    // 2: WB holds the port 3 cycles while r7 waits
    wb_we = 1; wb_rd = 3; wb_data = 32'h33;
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'hBEEF;
    cycle();
    mdu_valid = 0;
    chk("t2_pending", pending, 1);
    cycle();
    cycle();
    wb_we = 0;
    #1 chk("t2_rf_waddr", rf_waddr, 7);
    cycle();
    chk("t2_pending0", pending, 0);

    // 3: fill FIFO under WB pressure, third offer held
    wb_we = 1; wb_rd = 4; wb_data = 32'h44;
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hA;
    cycle();
    mdu_rd = 11; mdu_data = 32'hB;
    cycle();
    mdu_rd = 12; mdu_data = 32'hC;
    #1 chk("t3_ready", mdu_ready, 0);
    cycle();
    wb_we = 0;
    cycle();
    mdu_valid = 0;
    cycle();
    cycle();

    // 4: WB to r0 frees the port
    mdu_valid = 1; mdu_rd = 13; mdu_data = 32'hD;
    cycle();
    mdu_valid = 0;
    wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF;
    #1 chk("t4_rf_waddr", rf_waddr, 13);
    cycle();
    wb_we = 0;

    // 5: WAW on busy r9; the stalled op does not re-set
    mdu_issue(8);
    cycle();
    mdu_issue(9);
    cycle();
    mdu_issue(9);
    #1 chk("t5_stall", stall, 1);
    cycle();
    id_clear();
    chk("t5_busy", busy_vec, 32'h300);

    // 6: reset with two entries pending and r8/r9 busy
    wb_we = 1; wb_rd = 2; wb_data = 32'h22;
    mdu_valid = 1; mdu_rd = 8; mdu_data = 32'h8;
    cycle();
    mdu_rd = 9; mdu_data = 32'h9;
    cycle();
    mdu_valid = 0;
    chk("t6_pending", pending, 2);
    wb_we = 0;
    #2 reset = 1'b1;
    #1;
    q.delete();
    m_busy = '0;
    chk("t6_pending_rst", pending, 0);
    chk("t6_busy_rst", busy_vec, 0);
    chk("t6_ready_rst", mdu_ready, 1);
    chk("t6_rf_we_rst", rf_we, 0);
    @(posedge clk);
    #1 chk("t6_rf_we_hold", rf_we, 0);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      id_valid   = $urandom_range(0, 1);
      id_rs      = 5'($urandom_range(0, 7));
      id_rt      = 5'($urandom_range(0, 7));
      id_rd      = 5'($urandom_range(0, 7));
      id_rs_used = $urandom_range(0, 1);
      id_rt_used = $urandom_range(0, 1);
      id_rd_we   = $urandom_range(0, 1);
      id_mdu     = ($urandom_range(0, 3) == 0);
      wb_we      = ($urandom_range(0, 2) == 0);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      mdu_valid  = $urandom_range(0, 1);
      mdu_rd     = 5'($urandom_range(0, 7));
      mdu_data   = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
